// File: rtl/spc_stack.sv
// Subroutine-PC stack: return-address RAM, pointer, occupancy, flags.
// Ports: clk, reset (async, active-low), state_fetch, spcw, spcnt,
//   spush, swp, srp, spcclr in; spco, spcptr, spcdepth, spc_empty,
//   spc_full, spc_ovf, spc_unf out.
// Optional macro SPC_OVF_TRAP_EN: block push-when-full and
//   pop-when-empty and raise sticky spc_ovf / spc_unf.
module spc_stack #(
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  state_fetch,
  input  logic [DATA_WIDTH-1:0] spcw,
  input  logic                  spcnt,
  input  logic                  spush,
  input  logic                  swp,
  input  logic                  srp,
  input  logic                  spcclr,
  output logic [DATA_WIDTH-1:0] spco,
  output logic [ADDR_WIDTH-1:0] spcptr,
  output logic [ADDR_WIDTH:0]   spcdepth,
  output logic                  spc_empty,
  output logic                  spc_full,
  output logic                  spc_ovf,
  output logic                  spc_unf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] ONE_D =
    (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mv;
  logic                  push_mv;
  logic                  pop_mv;
  logic                  we;
  logic [ADDR_WIDTH-1:0] spcadr;
  logic [ADDR_WIDTH-1:0] ptr_nxt;
  logic [ADDR_WIDTH:0]   depth_nxt;
  logic [DATA_WIDTH-1:0] spco_nxt;

  assign spc_empty = (spcdepth == '0);
  assign spc_full  = (spcdepth == DEPTH_V);

  // Clear outranks any move, so a move never coexists with clear.
  assign mv = state_fetch && spcnt && !spcclr;

  // A push writes the slot above top; anything else replaces top.
  assign spcadr = (spcnt && spush) ? spcptr + ONE_A : spcptr;

`ifdef SPC_OVF_TRAP_EN
  logic ovf_hit;
  logic unf_hit;
  logic ovf_q;
  logic unf_q;

  assign ovf_hit = mv && spush && spc_full;
  assign unf_hit = mv && !spush && spc_empty;
  assign push_mv = mv && spush && !spc_full;
  assign pop_mv  = mv && !spush && !spc_empty;
  assign we      = swp && !spcclr && !ovf_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (spcclr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_hit;
      unf_q <= unf_q | unf_hit;
    end
  end

  assign spc_ovf = ovf_q;
  assign spc_unf = unf_q;
`else
  assign push_mv = mv && spush;
  assign pop_mv  = mv && !spush;
  assign we      = swp && !spcclr;
  assign spc_ovf = 1'b0;
  assign spc_unf = 1'b0;
`endif

  // Pointer wraps modulo DEPTH; occupancy saturates at 0 / DEPTH.
  always_comb begin
    ptr_nxt   = spcptr;
    depth_nxt = spcdepth;
    unique case (1'b1)
      spcclr: begin
        ptr_nxt   = '0;
        depth_nxt = '0;
      end
      push_mv: begin
        ptr_nxt = spcptr + ONE_A;
        if (!spc_full) depth_nxt = spcdepth + ONE_D;
      end
      pop_mv: begin
        ptr_nxt = spcptr - ONE_A;
        if (!spc_empty) depth_nxt = spcdepth - ONE_D;
      end
      default: ;
    endcase
  end

  // Top-of-stack reads the post-update slot, forwarding this
  // cycle's write when it lands on that slot.
  always_comb begin
    spco_nxt = spco;
    if (spcclr) begin
      spco_nxt = '0;
    end else if (srp) begin
      if (we && (spcadr == ptr_nxt)) spco_nxt = spcw;
      else spco_nxt = mem[ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[spcadr] <= spcw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spco     <= '0;
      spcptr   <= '0;
      spcdepth <= '0;
    end else begin
      spco     <= spco_nxt;
      spcptr   <= ptr_nxt;
      spcdepth <= depth_nxt;
    end
  end

endmodule

// File: tb/tb_spc_stack.sv
// Self-checking bench for spc_stack: vector table plus
// multi-cycle sequences for fill/overflow, underflow and reset.
module tb_spc_stack;

`ifdef SPC_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        state_fetch;
  logic [18:0] spcw;
  logic        spcnt;
  logic        spush;
  logic        swp;
  logic        srp;
  logic        spcclr;
  logic [18:0] spco;
  logic [4:0]  spcptr;
  logic [5:0]  spcdepth;
  logic        spc_empty;
  logic        spc_full;
  logic        spc_ovf;
  logic        spc_unf;

  spc_stack dut (
    .clk        (clk),
    .reset      (reset),
    .state_fetch(state_fetch),
    .spcw       (spcw),
    .spcnt      (spcnt),
    .spush      (spush),
    .swp        (swp),
    .srp        (srp),
    .spcclr     (spcclr),
    .spco       (spco),
    .spcptr     (spcptr),
    .spcdepth   (spcdepth),
    .spc_empty  (spc_empty),
    .spc_full   (spc_full),
    .spc_ovf    (spc_ovf),
    .spc_unf    (spc_unf)
  );

  typedef struct {
    logic        sf;
    logic        cnt;
    logic        psh;
    logic        wp;
    logic        rp;
    logic        clr;
    logic [18:0] w;
    logic [18:0] e_spco;
    logic [4:0]  e_ptr;
    logic [5:0]  e_depth;
    logic        e_empty;
    logic        e_full;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    input logic sf, input logic cnt, input logic psh,
    input logic wp, input logic rp, input logic clr,
    input logic [18:0] w, input logic [18:0] es,
    input logic [4:0] ep, input logic [5:0] ed,
    input logic ee, input logic ef,
    input logic eo, input logic eu);
    vec_t v;
    v.sf = sf; v.cnt = cnt; v.psh = psh;
    v.wp = wp; v.rp = rp; v.clr = clr; v.w = w;
    v.e_spco = es; v.e_ptr = ep; v.e_depth = ed;
    v.e_empty = ee; v.e_full = ef;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(input string tag, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h",
               tag, nm, act, exp);
    end
  endtask

  task automatic idle();
    state_fetch = 0; spcnt = 0; spush = 0;
    swp = 0; srp = 0; spcclr = 0; spcw = '0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    state_fetch = v.sf; spcnt = v.cnt; spush = v.psh;
    swp = v.wp; srp = v.rp; spcclr = v.clr; spcw = v.w;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk(tag, "scoreboard", 0, 1);
    end else begin
      e = sb.pop_front();
      chk(tag, "spco",  32'(spco),      32'(e.e_spco));
      chk(tag, "ptr",   32'(spcptr),    32'(e.e_ptr));
      chk(tag, "depth", 32'(spcdepth),  32'(e.e_depth));
      chk(tag, "empty", 32'(spc_empty), 32'(e.e_empty));
      chk(tag, "full",  32'(spc_full),  32'(e.e_full));
      chk(tag, "ovf",   32'(spc_ovf),   32'(e.e_ovf));
      chk(tag, "unf",   32'(spc_unf),   32'(e.e_unf));
    end
  endtask

  vec_t clr_v;
  vec_t tbl[13];

  initial begin
    clr_v = mk(0,0,0,0,0,1, 19'h0,
               19'h0, 5'd0, 6'd0, 1,0,0,0);
    tbl[0]  = clr_v;
    tbl[1]  = mk(1,1,1,1,1,0, 19'h12345,
                 19'h12345, 5'd1, 6'd1, 0,0,0,0);
    tbl[2]  = clr_v;
    tbl[3]  = mk(1,1,1,1,1,0, 19'h00001,
                 19'h00001, 5'd1, 6'd1, 0,0,0,0);
    tbl[4]  = mk(1,1,1,1,1,0, 19'h00002,
                 19'h00002, 5'd2, 6'd2, 0,0,0,0);
    tbl[5]  = mk(1,1,1,1,1,0, 19'h00003,
                 19'h00003, 5'd3, 6'd3, 0,0,0,0);
    tbl[6]  = mk(1,1,0,0,1,0, 19'h0,
                 19'h00002, 5'd2, 6'd2, 0,0,0,0);
    tbl[7]  = mk(1,1,0,0,1,0, 19'h0,
                 19'h00001, 5'd1, 6'd1, 0,0,0,0);
    tbl[8]  = mk(1,0,0,1,1,0, 19'h7FFFF,
                 19'h7FFFF, 5'd1, 6'd1, 0,0,0,0);
    tbl[9]  = mk(0,0,0,0,0,0, 19'h0,
                 19'h7FFFF, 5'd1, 6'd1, 0,0,0,0);
    tbl[10] = mk(0,1,1,0,1,0, 19'h0,
                 19'h7FFFF, 5'd1, 6'd1, 0,0,0,0);
    tbl[11] = mk(1,1,0,0,0,0, 19'h0,
                 19'h7FFFF, 5'd0, 6'd0, 1,0,0,0);
    tbl[12] = mk(0,0,0,1,1,0, 19'h0ABCD,
                 19'h0ABCD, 5'd0, 6'd0, 1,0,0,0);

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst", "spco",  32'(spco),      0);
    chk("rst", "ptr",   32'(spcptr),    0);
    chk("rst", "depth", 32'(spcdepth),  0);
    chk("rst", "empty", 32'(spc_empty), 1);
    chk("rst", "ovf",   32'(spc_ovf),   0);
    chk("rst", "unf",   32'(spc_unf),   0);

    for (int i = 0; i < 13; i++)
      apply($sformatf("tbl%0d", i), tbl[i]);

    // Fill all 32 slots, then push once more.
    apply("fill_clr", clr_v);
    for (int i = 0; i < 32; i++)
      apply($sformatf("fill%0d", i),
            mk(1,1,1,1,1,0, 19'(i), 19'(i),
               5'((i + 1) % 32), 6'(i + 1),
               0, (i == 31), 0, 0));
    apply("push33",
          mk(1,1,1,1,1,0, 19'h55555,
             TRAP ? 19'd31 : 19'h55555,
             TRAP ? 5'd0 : 5'd1, 6'd32,
             0, 1, TRAP, 0));
    apply("ovf_clr", clr_v);

    // Pop from empty.
    apply("pop_empty",
          mk(1,1,0,0,0,0, 19'h0, 19'h0,
             TRAP ? 5'd0 : 5'd31, 6'd0,
             1, 0, 0, TRAP));
    apply("unf_clr", clr_v);

    // Asynchronous reset at depth 5.
    for (int i = 1; i <= 5; i++)
      apply($sformatf("pre%0d", i),
            mk(1,1,1,1,1,0, 19'(i), 19'(i),
               5'(i), 6'(i), 0, 0, 0, 0));
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("arst", "spco",  32'(spco),      0);
    chk("arst", "ptr",   32'(spcptr),    0);
    chk("arst", "depth", 32'(spcdepth),  0);
    chk("arst", "empty", 32'(spc_empty), 1);
    chk("arst", "ovf",   32'(spc_ovf),   0);
    chk("arst", "unf",   32'(spc_unf),   0);
    @(negedge clk);
    reset = 1'b1;
    apply("post_pop",
          mk(1,1,0,0,0,0, 19'h0, 19'h0,
             TRAP ? 5'd0 : 5'd31, 6'd0,
             1, 0, 0, TRAP));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/spc_stack.md
Name: spc_stack

Overview:
- Parametrised subroutine-PC stack: return-address RAM plus pointer, with a registered top-of-stack output.
- Adds occupancy tracking, full/empty status, sticky overflow/underflow flags and a synchronous clear.
- Sits beside the sequencer. Push/pop take effect on state_fetch; writes take effect on any swp cycle.
- Drop-in superset of the existing SPC interface at default parameters.

Parameters:
- DATA_WIDTH, 19, width of each stack entry (return PC plus flag bits).
- ADDR_WIDTH, 5, pointer width; stack depth DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- state_fetch  input  1  pointer/occupancy update enable.
- spcw  input  DATA_WIDTH  write data.
- spcnt  input  1  pointer move request; qualified by state_fetch.
- spush  input  1  direction: 1 = push (increment), 0 = pop (decrement).
- swp  input  1  RAM write strobe.
- srp  input  1  output register load enable.
- spcclr  input  1  synchronous clear of pointer, occupancy and flags.
- spco  output  DATA_WIDTH  registered top-of-stack.
- spcptr  output  ADDR_WIDTH  current pointer.
- spcdepth  output  ADDR_WIDTH+1  occupied entries, 0..DEPTH.
- spc_empty  output  1  spcdepth == 0.
- spc_full  output  1  spcdepth == DEPTH.
- spc_ovf  output  1  sticky push-when-full flag.
- spc_unf  output  1  sticky pop-when-empty flag.

Behaviour:
- Reset (reset=0, asynchronous): spco=0, spcptr=0, spcdepth=0, spc_ovf=0, spc_unf=0. RAM contents are not cleared. Reset may assert mid-operation; the same cycle's write is not guaranteed.
- Write address: spcadr = spcptr+1 (mod DEPTH) when spcnt && spush, else spcptr. Push writes the slot above top; otherwise swp replaces top.
- swp=1: RAM[spcadr] <= spcw on the edge, independent of state_fetch.
- Move cycle (mv = state_fetch && spcnt):
  - push: spcptr+1, spcdepth+1.
  - pop: spcptr-1, spcdepth-1.
  - Pointer arithmetic is modulo DEPTH.
- spco: when srp=1, loads RAM[next spcptr], i.e. the post-update pointer value.
  - Same-cycle forwarding: if swp writes that address, spco loads spcw (new data, not old).
  - When srp=0, spco holds.
  - Latency: one clock from the push/pop edge to spco valid.
- spcclr=1: highest non-reset priority. spcptr=0, spcdepth=0, flags=0; swp write and move are suppressed; spco=0.
- spc_empty and spc_full are combinational from spcdepth.
- swp with no move (replace top) is legal at any depth and never flags.
- The pointer can wrap past DEPTH with the macro disabled; this is legacy behaviour.

Optional Feature:
- Macro: SPC_OVF_TRAP_EN.
- Defined:
  - Push with spc_full=1: spcptr, spcdepth and the RAM write are suppressed; spc_ovf sets and stays set until reset or spcclr.
  - Pop with spc_empty=1: spcptr and spcdepth are unchanged; spc_unf sets.
  - spco reloads the unchanged top if srp=1.
- Undefined:
  - Pointer wraps freely and the write is performed (legacy SPC behaviour).
  - spcdepth saturates at DEPTH on push and at 0 on pop.
  - spc_ovf and spc_unf are tied 0.

Test Plan:
- Reset release, then push 19'h12345 (state_fetch=1, spcnt=1, spush=1, swp=1, srp=1) -> next cycle spcptr=1, spcdepth=1, spco=19'h12345, spc_empty=0.
- Push 19'h00001, 19'h00002, 19'h00003, then pop twice with srp=1 -> spco goes 3, 2, 1; spcptr ends 1; spcdepth ends 1.
- Replace top with swp=1, spcnt=0, srp=1, spcw=19'h7FFFF -> spco=19'h7FFFF next cycle; spcptr and spcdepth unchanged.
- 32 pushes of values 0..31, then a 33rd push of 19'h55555:
  - With SPC_OVF_TRAP_EN: spc_full=1, spc_ovf=1, spcptr=0, spco=31.
  - Without it: spcptr=1, spco=19'h55555, spc_ovf=0.
- From empty, pop once:
  - With the macro: spc_unf=1, spcptr=0, spcdepth=0.
  - Without it: spcptr=31, spcdepth=0.
  - In both cases, spcclr=1 for one cycle clears the flags and pointer.
- reset=0 asserted mid-sequence at spcdepth=5 -> all outputs 0 immediately, without waiting for a clock edge. After release, a pop with trap enabled sets spc_unf.
